// File: rtl/bz_link_tx.sv
`default_nettype none
// ============================================================================
// Module   : bz_link_tx
// Purpose  : Inter-board link transmitter. Buffers routed packets in a small
//            FIFO and serializes each one into four 11-bit flits (HDR,D0-D2).
// Revision : 1.0 - initial release
// ============================================================================
module bz_link_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pkt_in_valid,
  output logic             pkt_in_ready,
  input  logic [9:0]       pkt_in_route,
  input  logic [31:0]      pkt_in_payload,
  output logic [10:0]      top_out,
  output logic             top_valid_out,
  input  logic             top_ready_out,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int c_AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_D0   = 3'd2,
    S_D1   = 3'd3,
    S_D2   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [41:0]      r_mem [FIFO_DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic [41:0]      r_hold;
  logic [41:0]      w_hold_nxt;
  logic [10:0]      r_top_out;
  logic [10:0]      w_flit_nxt;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_xfer;
  logic             w_count_inc;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_push  = pkt_in_valid & ~w_full;
  assign w_xfer  = r_valid & top_ready_out;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_count_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: if (w_xfer) w_state_nxt = S_D0;
      S_D0:  if (w_xfer) w_state_nxt = S_D1;
      S_D1:  if (w_xfer) w_state_nxt = S_D2;
      S_D2: begin
        if (w_xfer) begin
          w_count_inc = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_HDR;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_hold_nxt = w_pop ? r_mem[r_rd_ptr[c_AW-1:0]] : r_hold;

  // Flit for the state being entered, so top_out is registered yet current.
  always_comb begin
    w_flit_nxt = 11'd0;
    case (w_state_nxt)
      S_HDR:   w_flit_nxt = {1'b0, w_hold_nxt[41:32]};
      S_D0:    w_flit_nxt = w_hold_nxt[10:0];
      S_D1:    w_flit_nxt = w_hold_nxt[21:11];
      S_D2:    w_flit_nxt = {1'b0, w_hold_nxt[31:22]};
      default: w_flit_nxt = 11'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {pkt_in_route, pkt_in_payload};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_hold    <= '0;
      r_top_out <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_top_out <= w_flit_nxt;
      r_valid   <= (w_state_nxt != S_IDLE);
      if (w_push)      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_count_inc) r_count  <= r_count + CNT_W'(1);
    end
  end

  assign pkt_in_ready  = ~w_full;
  assign top_out       = r_top_out;
  assign top_valid_out = r_valid;
  assign busy          = (r_state != S_IDLE) | ~w_empty;
  assign pkt_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bz_link_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bz_link_tx
// Purpose  : Self-checking bench for bz_link_tx (flit scoreboard + directed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bz_link_tx;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pkt_in_valid = 1'b0;
  logic          pkt_in_ready;
  logic [9:0]    pkt_in_route = '0;
  logic [31:0]   pkt_in_payload = '0;
  logic [10:0]   top_out;
  logic          top_valid_out;
  logic          top_ready_out = 1'b0;
  logic          busy;
  logic [CW-1:0] pkt_count;

  always #5 clk = ~clk;

  bz_link_tx #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pkt_in_valid   (pkt_in_valid),
    .pkt_in_ready   (pkt_in_ready),
    .pkt_in_route   (pkt_in_route),
    .pkt_in_payload (pkt_in_payload),
    .top_out        (top_out),
    .top_valid_out  (top_valid_out),
    .top_ready_out  (top_ready_out),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  typedef struct {
    logic [9:0]  route;
    logic [31:0] payload;
    logic [10:0] hdr;
    logic [10:0] d0;
    logic [10:0] d1;
    logic [10:0] d2;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [10:0]   exp_q [$];
  int            idx = 0;
  logic [CW-1:0] cnt_model = '0;
  logic          prev_stall = 1'b0;
  logic [10:0]   prev_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flit monitor: compares every transfer against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("pkt_count", pkt_count, cnt_model);
        if (prev_stall) begin
          check("stall_out", top_out, prev_out);
          check("stall_valid", top_valid_out, 1);
        end
        if (idx != 0) check("valid_mid_pkt", top_valid_out, 1);
        if (top_valid_out && top_ready_out) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_flit: got %0h expected none", top_out);
          end else begin
            check("flit", top_out, exp_q.pop_front());
          end
          if (idx == 3) begin
            idx = 0;
            cnt_model = cnt_model + 1'b1;
          end else begin
            idx = idx + 1;
          end
        end
        prev_stall = top_valid_out && !top_ready_out;
        prev_out   = top_out;
      end
    end
  end

  task automatic push_exp(input int v);
    exp_q.push_back(vecs[v].hdr);
    exp_q.push_back(vecs[v].d0);
    exp_q.push_back(vecs[v].d1);
    exp_q.push_back(vecs[v].d2);
  endtask

  task automatic offer(input int v, input int budget, output bit acc);
    acc            = 1'b0;
    pkt_in_valid   = 1'b1;
    pkt_in_route   = vecs[v].route;
    pkt_in_payload = vecs[v].payload;
    for (int c = 0; c < budget && !acc; c++) begin
      @(negedge clk);
      if (pkt_in_ready) begin
        push_exp(v);
        acc = 1'b1;
      end
      tick();
    end
    pkt_in_valid = 1'b0;
  endtask

  task automatic send(input int v);
    bit acc;
    offer(v, 200, acc);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got not_accepted expected accepted (vec %0d)", v);
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 1000) begin
      tick();
      c++;
    end
    check("drain_timeout", (c < 1000) ? 1 : 0, 1);
    check("drain_valid_low", top_valid_out, 0);
    check("drain_busy_low", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    idx        = 0;
    cnt_model  = '0;
    prev_stall = 1'b0;
    check("rst_valid", top_valid_out, 0);
    check("rst_out", top_out, 0);
    check("rst_count", pkt_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", pkt_in_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int n_acc;
    int n_valid;
    vecs[0] = '{10'h003, 32'h4C70F07C, 11'h003, 11'h07C, 11'h61E, 11'h131};
    vecs[1] = '{10'h3FF, 32'hFFFFFFFF, 11'h3FF, 11'h7FF, 11'h7FF, 11'h3FF};
    vecs[2] = '{10'h000, 32'h00000000, 11'h000, 11'h000, 11'h000, 11'h000};
    vecs[3] = '{10'h155, 32'h80000001, 11'h155, 11'h001, 11'h000, 11'h200};
    vecs[4] = '{10'h2AA, 32'h00000800, 11'h2AA, 11'h000, 11'h001, 11'h000};
    vecs[5] = '{10'h001, 32'h00400000, 11'h001, 11'h000, 11'h000, 11'h001};
    vecs[6] = '{10'h002, 32'h12345678, 11'h002, 11'h678, 11'h68A, 11'h048};

    tick();
    tick();
    do_reset();

    // Single packet
    top_ready_out = 1'b1;
    send(0);
    wait_drain();
    check("single_count", pkt_count, 1);

    // Backpressure while D1 is shown
    send(0);
    n_valid = 0;
    while (!(top_valid_out && top_out == 11'h61E) && n_valid < 50) begin
      tick();
      n_valid++;
    end
    check("bp_reach_d1", (n_valid < 50) ? 1 : 0, 1);
    top_ready_out = 1'b0;
    repeat (5) begin
      tick();
      check("bp_hold_out", top_out, 11'h61E);
      check("bp_hold_valid", top_valid_out, 1);
    end
    top_ready_out = 1'b1;
    wait_drain();
    check("bp_count", pkt_count, 2);

    // Table of flit formats, one packet at a time
    for (int v = 0; v < NV; v++) begin
      send(v);
      wait_drain();
    end

    // Back-to-back routes 1,2,3
    do_reset();
    top_ready_out = 1'b1;
    n_valid = 0;
    fork
      begin
        send(5);
        send(6);
        send(0);
      end
      begin
        for (int c = 0; c < 20 && !top_valid_out; c++) tick();
        repeat (12) begin
          if (top_valid_out) n_valid++;
          tick();
        end
      end
    join
    check("b2b_valid_cycles", n_valid, 12);
    check("b2b_end_valid", top_valid_out, 0);
    wait_drain();
    check("b2b_count", pkt_count, 3);

    // Full FIFO with far end stalled
    do_reset();
    top_ready_out = 1'b0;
    n_acc = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      offer(k % NV, 6, acc);
      if (acc) n_acc++;
    end
    check("full_accepted", n_acc, DEPTH + 1);
    check("full_ready_low", pkt_in_ready, 0);
    check("full_busy", busy, 1);
    top_ready_out = 1'b1;
    wait_drain();
    check("full_count", pkt_count, DEPTH + 1);

    // Reset mid-packet with two packets queued
    do_reset();
    top_ready_out = 1'b1;
    send(3);
    send(4);
    send(6);
    check("pre_rst_d0", top_out, vecs[3].d0);
    check("pre_rst_valid", top_valid_out, 1);
    do_reset();
    send(1);
    wait_drain();
    check("post_rst_count", pkt_count, 1);

    // Counter wrap at CNT_W = 4
    do_reset();
    for (int k = 0; k < 17; k++) send(k % NV);
    wait_drain();
    check("wrap_count", pkt_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
